// File: rtl/mux_recirc_tx.sv
// Source-domain side of the mux-recirculation CDC path: holds a word on tx_data,
// raises tx_req, and closes a 4-phase req/ack handshake on a synchronized rx_ack.
module mux_recirc_tx #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_req,
    input  logic             rx_ack,
    output logic             done,
    output logic             err,
    input  logic             err_clr
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;
    logic [CW-1:0]          wait_q, wait_d;
    logic                   stay, to_hit;
    logic [WIDTH-1:0]       data_q;
    logic                   req_q, done_q, err_q;

    // Plain flop chain: nothing may sit between the synchronizer stages.
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx_ack};
    end

    assign ack_s    = sync_q[SYNC_STAGES-1];
    assign in_ready = (state_q == IDLE) && !ack_s;

    // Wait counter runs only while the FSM is parked in REQ or REL.
    always_comb begin
        stay   = ((state_q == REQ) && !ack_s) || ((state_q == REL) && ack_s);
        wait_d = '0;
        if (stay) wait_d = (wait_q == TO_MAX) ? wait_q : wait_q + CW'(1);
        to_hit = (TIMEOUT != 0) && stay && (wait_q != TO_MAX) && (wait_d == TO_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wait_q  <= '0;
        end else begin
            done_q <= 1'b0;
            wait_q <= wait_d;
            if (to_hit)       err_q <= 1'b1;
            else if (err_clr) err_q <= 1'b0;
            case (state_q)
                IDLE: if (in_valid && in_ready) begin
                    data_q  <= in_data;
                    req_q   <= 1'b1;
                    state_q <= REQ;
                end
                REQ: if (ack_s) begin
                    req_q   <= 1'b0;
                    state_q <= REL;
                end
                REL: if (!ack_s) begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_data = data_q;
    assign tx_req  = req_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule
